// File: rtl/multiplier_datapath.sv
// Register/arithmetic half of the shift-add signed multiplier: X/A/B registers driven by Controller commands.
// Optional SHIFT_COUNT_EN macro adds a saturating shift counter (ShiftCnt) and Done flag.
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA_LoadB,
    input  logic             Clr_Ld,
    input  logic             Shift,
    input  logic             Add,
    input  logic             Sub,
    input  logic [WIDTH-1:0] S,
    output logic             M,
    output logic             X,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic [3:0]       ShiftCnt,
    output logic             Done
);

    logic             x_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic signed [WIDTH:0] sum;

    // Both operands are sign-extended to WIDTH+1 bits so every add/sub result is exact.
    function automatic logic signed [WIDTH:0] add_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] s,
        input logic             sub
    );
        logic signed [WIDTH:0] a_ext;
        logic signed [WIDTH:0] s_ext;
        a_ext = {a[WIDTH-1], a};
        s_ext = {s[WIDTH-1], s};
        return sub ? (a_ext - s_ext) : (a_ext + s_ext);
    endfunction

    always_comb begin
        sum = add_sub(a_reg, S, Sub);
    end

    // Priority Clr_Ld > Sub > Add > Shift; Sub selects subtraction inside the shared adder.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (Clr_Ld) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            if (ClearA_LoadB) begin
                b_reg <= S;
            end
        end else if (Sub || Add) begin
            {x_reg, a_reg} <= sum;
        end else if (Shift) begin
            a_reg <= {x_reg, a_reg[WIDTH-1:1]};
            b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
        end
    end

    assign M    = b_reg[0];
    assign X    = x_reg;
    assign Aval = a_reg;
    assign Bval = b_reg;

`ifdef SHIFT_COUNT_EN
    localparam logic [3:0] CNT_MAX = 4'(WIDTH);
    logic [3:0] cnt_reg;

    // Counts only shifts that actually execute, i.e. not pre-empted by a higher-priority command.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_reg <= 4'd0;
        end else if (Clr_Ld) begin
            cnt_reg <= 4'd0;
        end else if (Shift && !Add && !Sub && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign ShiftCnt = cnt_reg;
    assign Done     = (cnt_reg == CNT_MAX);
`else
    assign ShiftCnt = 4'd0;
    assign Done     = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: directed steps plus random commands against an integer model.
module tb_multiplier_datapath;

    localparam int WIDTH = 8;
`ifdef SHIFT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             ClearA_LoadB = 1'b0;
    logic             Clr_Ld = 1'b0;
    logic             Shift = 1'b0;
    logic             Add = 1'b0;
    logic             Sub = 1'b0;
    logic [WIDTH-1:0] S = '0;
    logic             M;
    logic             X;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic [3:0]       ShiftCnt;
    logic             Done;

    int checks = 0;
    int failures = 0;

    // Reference state as plain integers
    int mx = 0;
    int ma = 0;
    int mb = 0;
    int mcnt = 0;

    multiplier_datapath #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Clr_Ld(Clr_Ld),
        .Shift(Shift), .Add(Add), .Sub(Sub), .S(S), .M(M), .X(X),
        .Aval(Aval), .Bval(Bval), .ShiftCnt(ShiftCnt), .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; ma = 0; mb = 0; mcnt = 0;
    endtask

    // Behavioural rules: signed integer add/sub, and a 17-bit arithmetic right shift of {X,A,B}
    task automatic model_step(input bit cl, input bit sh, input bit ad, input bit sb,
                              input bit lb, input int s);
        int v;
        if (cl) begin
            ma = 0; mx = 0; mcnt = 0;
            if (lb) mb = s;
        end else if (sb || ad) begin
            v = sb ? sx(ma) - sx(s) : sx(ma) + sx(s);
            mx = (v >> 8) & 1;
            ma = v & 255;
        end else if (sh) begin
            v = (mx << 16) | (ma << 8) | mb;
            if (mx != 0) v = v - (1 << 17);
            v = v >>> 1;
            mx = (v >> 16) & 1;
            ma = (v >> 8) & 255;
            mb = v & 255;
            if (mcnt < WIDTH) mcnt++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".X"}, 32'(X), 32'(mx));
        chk({tag, ".A"}, 32'(Aval), 32'(ma));
        chk({tag, ".B"}, 32'(Bval), 32'(mb));
        chk({tag, ".M"}, 32'(M), 32'(mb & 1));
        chk({tag, ".cnt"}, 32'(ShiftCnt), CNT_EN ? 32'(mcnt) : 32'd0);
        chk({tag, ".done"}, 32'(Done), (CNT_EN && mcnt == WIDTH) ? 32'd1 : 32'd0);
    endtask

    task automatic do_cmd(input string tag, input bit cl, input bit sh, input bit ad,
                          input bit sb, input bit lb, input logic [7:0] s);
        @(negedge Clk);
        Clr_Ld = cl; Shift = sh; Add = ad; Sub = sb; ClearA_LoadB = lb; S = s;
        @(posedge Clk);
        model_step(cl, sh, ad, sb, lb, int'(s));
        #1;
        check_all(tag);
        @(negedge Clk);
        Clr_Ld = 0; Shift = 0; Add = 0; Sub = 0; ClearA_LoadB = 0;
    endtask

    initial begin
        // Power-on reset
        #12;
        chk("reset.X", 32'(X), 32'd0);
        chk("reset.A", 32'(Aval), 32'd0);
        chk("reset.B", 32'(Bval), 32'd0);
        chk("reset.M", 32'(M), 32'd0);
        @(negedge Clk);
        Reset = 0;
        model_reset();

        // Reset mid-operation with A=0x55, B=0xAA
        do_cmd("ld_aa", 1, 0, 0, 0, 1, 8'hAA);
        do_cmd("add_55", 0, 0, 1, 0, 0, 8'h55);
        chk("pre_rst.A", 32'(Aval), 32'h55);
        chk("pre_rst.B", 32'(Bval), 32'hAA);
        #2;
        Reset = 1;
        #1;
        model_reset();
        chk("async_rst.X", 32'(X), 32'd0);
        chk("async_rst.A", 32'(Aval), 32'd0);
        chk("async_rst.B", 32'(Bval), 32'd0);
        chk("async_rst.M", 32'(M), 32'd0);
        chk("async_rst.done", 32'(Done), 32'd0);
        @(negedge Clk);
        Reset = 0;

        // Load B=0xFD
        do_cmd("load_fd", 1, 0, 0, 0, 1, 8'hFD);
        chk("load_fd.Bconst", 32'(Bval), 32'hFD);
        chk("load_fd.Mconst", 32'(M), 32'd1);
        // Clr_Ld without ClearA_LoadB holds B
        do_cmd("clr_hold", 1, 0, 0, 0, 0, 8'h12);
        // ClearA_LoadB alone does nothing
        do_cmd("lb_alone", 0, 0, 0, 0, 1, 8'h34);

        // Add then Sub of 7 from A=0
        do_cmd("add7", 0, 0, 1, 0, 0, 8'h07);
        chk("add7.Aconst", 32'(Aval), 32'h07);
        do_cmd("clr_a", 1, 0, 0, 0, 1, 8'h03);
        do_cmd("sub7", 0, 0, 0, 1, 0, 8'h07);
        chk("sub7.Xconst", 32'(X), 32'd1);
        chk("sub7.Aconst", 32'(Aval), 32'hF9);

        // Shift of X=1,A=0xF9,B=0x03
        do_cmd("shift1", 0, 1, 0, 0, 0, 8'h00);
        chk("shift1.Aconst", 32'(Aval), 32'hFC);
        chk("shift1.Bconst", 32'(Bval), 32'h81);
        chk("shift1.Xconst", 32'(X), 32'd1);

        // Clr_Ld wins over Shift; then priority Sub > Add > Shift
        do_cmd("clr_shift", 1, 1, 0, 0, 0, 8'h00);
        do_cmd("sub_add_sh", 0, 1, 1, 1, 0, 8'h80);
        chk("sub_m128.Aconst", 32'(Aval), 32'h80);
        chk("sub_m128.Xconst", 32'(X), 32'd0);
        do_cmd("add_sh", 0, 1, 1, 0, 0, 8'h05);

        // Full multiply: -3 * 7
        do_cmd("mul_ld", 1, 0, 0, 0, 1, 8'hFD);
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (M) do_cmd("mul_add", 0, 0, 1, 0, 0, 8'h07);
            do_cmd("mul_sh", 0, 1, 0, 0, 0, 8'h07);
        end
        if (M) do_cmd("mul_sub", 0, 0, 0, 1, 0, 8'h07);
        do_cmd("mul_sh_last", 0, 1, 0, 0, 0, 8'h07);
        chk("mul.product", {16'd0, Aval, Bval}, 32'hFFEB);
        chk("mul.X", 32'(X), 32'd1);

        // Counter saturation and clear
        do_cmd("cnt_clr", 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) do_cmd("cnt_sh", 0, 1, 0, 0, 0, 8'h00);
        do_cmd("cnt_clr2", 1, 0, 0, 0, 0, 8'h00);

        // Random command mix
        for (int i = 0; i < 300; i++) begin
            logic [4:0] c;
            c = 5'($urandom);
            do_cmd("rand", (c[0] && c[4]), c[1], c[2], (c[3] && c[0]), 1'($urandom),
                   8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
